// File: rtl/vector_alu_pkg.sv
// Shared types and lane arithmetic helpers for the vector ALU pipe.
// Pure definitions: no latency and no flow control of its own.
package vector_alu_pkg;

    localparam int LANE_W_MAX = 16;

    typedef enum logic [2:0] {
        OP_ZERO  = 3'b000,
        OP_PASS  = 3'b001,
        OP_ADDS  = 3'b010,
        OP_SUBS  = 3'b011,
        OP_MULN  = 3'b100,
        OP_DIV   = 3'b101,
        OP_BLEND = 3'b110,
        OP_ZERO2 = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV,
        ST_HOLD
    } state_e;

    // Rounded a*b/(2^w-1): the final add of t>>w folds the /255-style correction into a shift.
    function automatic logic [LANE_W_MAX-1:0] lane_muln(input logic [LANE_W_MAX-1:0] a,
                                                       input logic [LANE_W_MAX-1:0] b,
                                                       input int unsigned w);
        logic [2*LANE_W_MAX:0] t;
        logic [2*LANE_W_MAX:0] r;
        t = 33'(a) * 33'(b) + (33'd1 << (w - 1));
        r = (t + (t >> w)) >> w;
        return r[LANE_W_MAX-1:0];
    endfunction

endpackage

// File: rtl/vector_alu_pipe_if.sv
// Operand/result handshake bundle for vector_alu_pipe.
// Valid/ready on both the operand side and the result side.
interface vector_alu_pipe_if #(
    parameter int N      = 128,
    parameter int LANE_W = 8
);
    localparam int LANES = N / LANE_W;

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      A;
    logic [N-1:0]      B;
    logic [2:0]        Sel;
    logic [LANE_W-1:0] alpha;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      C;
    logic [LANES-1:0]  out_dz;
    logic              busy;

    modport slave (
        input  in_valid, A, B, Sel, alpha, out_ready,
        output in_ready, out_valid, C, out_dz, busy
    );

    modport master (
        output in_valid, A, B, Sel, alpha, out_ready,
        input  in_ready, out_valid, C, out_dz, busy
    );
endinterface

// File: rtl/vector_lane_divider.sv
// One-lane restoring divider, one quotient bit per step strobe.
// Latency LANE_W steps after start; no backpressure, the parent paces it.
module vector_lane_divider #(
    parameter int LANE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic [LANE_W-1:0] quo_nxt,
    output logic              dz
);
    logic [LANE_W-1:0] rem;
    logic [LANE_W-1:0] quo;
    logic [LANE_W-1:0] dvs;
    logic [LANE_W:0]   rem_sh;
    logic              ge;

    // A zero divisor makes every trial subtract succeed, so the quotient saturates to all ones.
    assign rem_sh  = {rem, quo[LANE_W-1]};
    assign ge      = rem_sh >= {1'b0, dvs};
    assign quo_nxt = {quo[LANE_W-2:0], ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            quo <= '0;
            dvs <= '0;
            dz  <= 1'b0;
        end else if (start) begin
            rem <= '0;
            quo <= a;
            dvs <= b;
            dz  <= (b == '0);
        end else if (step) begin
            rem <= ge ? LANE_W'(rem_sh - {1'b0, dvs}) : rem_sh[LANE_W-1:0];
            quo <= quo_nxt;
        end
    end
endmodule

// File: rtl/vector_alu_pipe.sv
// Lane-parallel saturating/normalised vector ALU with iterative divide.
// Latency 2 (DIV: LANE_W+1) counting the accept edge; result held in HOLD until out_ready.
module vector_alu_pipe
    import vector_alu_pkg::*;
#(
    parameter int N      = 128,
    parameter int LANE_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    vector_alu_pipe_if.slave io
);
    localparam int LANES = N / LANE_W;
    localparam int CW    = $clog2(LANE_W);
    localparam logic [LANE_W-1:0] M = '1;

    typedef struct packed {
        logic [N-1:0]      a;
        logic [N-1:0]      b;
        op_e               sel;
        logic [LANE_W-1:0] alpha;
    } opr_t;

    state_e           state;
    opr_t             opr;
    logic [CW-1:0]    cnt;
    logic             started;
    logic             out_valid_q;
    logic             busy_q;
    logic [N-1:0]     c_q;
    logic [LANES-1:0] dz_q;
    logic             in_ready;
    logic             accept;
    logic             div_start;
    logic [N-1:0]     exec_res;
    logic [N-1:0]     div_res;
    logic [LANES-1:0] div_dz;

    assign in_ready  = started && ((state == ST_IDLE) || (state == ST_HOLD && io.out_ready));
    assign accept    = io.in_valid && in_ready;
    assign div_start = accept && (op_e'(io.Sel) == OP_DIV);

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.busy      = busy_q;
    assign io.C         = c_q;
    assign io.out_dz    = dz_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_W-1:0] a, b, r, m_ab, m_a, m_b;
        logic [LANE_W:0]   sum, bsum;

        assign a = opr.a[l*LANE_W +: LANE_W];
        assign b = opr.b[l*LANE_W +: LANE_W];

        always_comb begin
            sum  = {1'b0, a} + {1'b0, b};
            m_ab = LANE_W'(lane_muln(LANE_W_MAX'(a), LANE_W_MAX'(b), LANE_W));
            m_a  = LANE_W'(lane_muln(LANE_W_MAX'(a), LANE_W_MAX'(opr.alpha), LANE_W));
            m_b  = LANE_W'(lane_muln(LANE_W_MAX'(b), LANE_W_MAX'(M - opr.alpha), LANE_W));
            bsum = {1'b0, m_a} + {1'b0, m_b};
            r    = '0;
            case (opr.sel)
                OP_PASS:  r = a;
                OP_ADDS:  r = sum[LANE_W] ? M : sum[LANE_W-1:0];
                OP_SUBS:  r = (a >= b) ? (a - b) : '0;
                OP_MULN:  r = m_ab;
                OP_BLEND: r = bsum[LANE_W] ? M : bsum[LANE_W-1:0];
                default:  r = '0;
            endcase
        end

        assign exec_res[l*LANE_W +: LANE_W] = r;

        vector_lane_divider #(.LANE_W(LANE_W)) u_div (
            .clk     (clk),
            .rst     (rst),
            .start   (div_start),
            .step    (state == ST_DIV),
            .a       (io.A[l*LANE_W +: LANE_W]),
            .b       (io.B[l*LANE_W +: LANE_W]),
            .quo_nxt (div_res[l*LANE_W +: LANE_W]),
            .dz      (div_dz[l])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            opr         <= '0;
            cnt         <= '0;
            started     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            c_q         <= '0;
            dz_q        <= '0;
        end else begin
            started <= 1'b1;
            if (accept) begin
                opr <= '{a: io.A, b: io.B, sel: op_e'(io.Sel), alpha: io.alpha};
            end
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        state       <= div_start ? ST_DIV : ST_EXEC;
                        cnt         <= CW'(LANE_W - 1);
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else if (state == ST_HOLD && io.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    c_q         <= exec_res;
                    dz_q        <= '0;
                    state       <= ST_HOLD;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                ST_DIV: begin
                    if (cnt == '0) begin
                        c_q         <= div_res;
                        dz_q        <= div_dz;
                        state       <= ST_HOLD;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_alu_pipe.sv
// Directed-vector bench for vector_alu_pipe (16 x 8-bit lanes).
module tb_vector_alu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vector_alu_pipe_if #(.N(128), .LANE_W(8)) vif ();

    vector_alu_pipe #(.N(128), .LANE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (vif.slave)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rep(input logic [7:0] x);
        return {16{x}};
    endfunction

    // Issue one operand set, scramble the inputs after accept, then measure latency and result.
    task automatic run_op(input string tag, input logic [2:0] sel, input logic [127:0] a,
                          input logic [127:0] b, input logic [7:0] al, input bit rdy,
                          input int lat_exp, input logic [127:0] c_exp, input logic [15:0] dz_exp);
        int cyc;
        @(negedge clk);
        vif.in_valid  = 1'b1;
        vif.Sel       = sel;
        vif.A         = a;
        vif.B         = b;
        vif.alpha     = al;
        vif.out_ready = rdy;
        #1 check({tag, "_in_ready"}, 128'(vif.in_ready), 128'(1));
        @(posedge clk);
        #1;
        vif.in_valid = 1'b0;
        vif.A        = ~a;
        vif.B        = ~b;
        vif.Sel      = ~sel;
        vif.alpha    = ~al;
        check({tag, "_busy"}, 128'(vif.busy), 128'(1));
        cyc = 1;
        while (!vif.out_valid && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({tag, "_lat"}, 128'(cyc), 128'(lat_exp));
        check({tag, "_c"}, vif.C, c_exp);
        check({tag, "_dz"}, 128'(vif.out_dz), 128'(dz_exp));
        if (rdy) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [127:0] va, vb, vc, pa, pb;
        logic [15:0]  dz;
        bit           stale;

        vif.in_valid  = 1'b0;
        vif.out_ready = 1'b1;
        vif.A         = '0;
        vif.B         = '0;
        vif.Sel       = '0;
        vif.alpha     = '0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 128'(vif.out_valid), 128'(0));
        check("rst_in_ready", 128'(vif.in_ready), 128'(0));
        check("rst_busy", 128'(vif.busy), 128'(0));
        check("rst_c", vif.C, 128'(0));
        check("rst_dz", 128'(vif.out_dz), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1 check("rst_rel_in_ready", 128'(vif.in_ready), 128'(1));

        // saturating add/sub
        run_op("adds_sat", 3'b010, rep(8'd200), rep(8'd100), 8'd0, 1'b1, 2, rep(8'd255), '0);
        run_op("subs_sat", 3'b011, rep(8'd50), rep(8'd100), 8'd0, 1'b1, 2, rep(8'd0), '0);
        run_op("adds_10_3", 3'b010, rep(8'd10), rep(8'd3), 8'd0, 1'b1, 2, rep(8'd13), '0);
        run_op("subs_10_3", 3'b011, rep(8'd10), rep(8'd3), 8'd0, 1'b1, 2, rep(8'd7), '0);

        // per-lane independence: lane i a=16i+15, b=8i -> min(24i+15,255)
        for (int i = 0; i < 16; i++) begin
            va[i*8 +: 8] = 8'(16*i + 15);
            vb[i*8 +: 8] = 8'(8*i);
            vc[i*8 +: 8] = (24*i + 15 > 255) ? 8'd255 : 8'(24*i + 15);
        end
        run_op("adds_lanes", 3'b010, va, vb, 8'd0, 1'b1, 2, vc, '0);

        // normalised multiply and blend
        run_op("muln_255", 3'b100, rep(8'd255), rep(8'd255), 8'd0, 1'b1, 2, rep(8'd255), '0);
        run_op("muln_128", 3'b100, rep(8'd128), rep(8'd128), 8'd0, 1'b1, 2, rep(8'd64), '0);
        run_op("blend_a255", 3'b110, rep(8'h40), rep(8'hC0), 8'd255, 1'b1, 2, rep(8'h40), '0);
        run_op("blend_a0", 3'b110, rep(8'h40), rep(8'hC0), 8'd0, 1'b1, 2, rep(8'hC0), '0);
        run_op("blend_a128", 3'b110, rep(8'd255), rep(8'd0), 8'd128, 1'b1, 2, rep(8'd128), '0);

        // iterative divide, with a zero divisor in lane 3
        run_op("div_200_7", 3'b101, rep(8'd200), rep(8'd7), 8'd0, 1'b1, 9, rep(8'd28), '0);
        vb = rep(8'd7);
        vb[31:24] = 8'd0;
        vc = rep(8'd28);
        vc[31:24] = 8'hFF;
        run_op("div_dz", 3'b101, rep(8'd200), vb, 8'd0, 1'b1, 9, vc, 16'h0008);

        // both zero opcodes, random operands
        va = {$urandom, $urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom, $urandom};
        run_op("zero_000", 3'b000, va, vb, 8'(($urandom)), 1'b1, 2, '0, '0);
        run_op("zero_111", 3'b111, vb, va, 8'(($urandom)), 1'b1, 2, '0, '0);

        // backpressure, then same-cycle consume-and-accept
        pa = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        pb = {$urandom, $urandom, $urandom, $urandom};
        run_op("bp_first", 3'b001, pa, pb, 8'd0, 1'b0, 2, pa, '0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 128'(vif.out_valid), 128'(1));
            check("bp_in_ready", 128'(vif.in_ready), 128'(0));
            check("bp_c_stable", vif.C, pa);
        end
        run_op("b2b_pass", 3'b001, pb, pa, 8'd0, 1'b1, 2, pb, '0);

        // reset during a divide
        @(negedge clk);
        vif.in_valid = 1'b1;
        vif.Sel      = 3'b101;
        vif.A        = rep(8'd99);
        vif.B        = rep(8'd5);
        @(posedge clk);
        #1 vif.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("mid_div_busy", 128'(vif.busy), 128'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 128'(vif.out_valid), 128'(0));
        check("mid_rst_c", vif.C, 128'(0));
        check("mid_rst_busy", 128'(vif.busy), 128'(0));
        check("mid_rst_in_ready", 128'(vif.in_ready), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        #1 check("mid_rel_in_ready_pre", 128'(vif.in_ready), 128'(0));
        @(posedge clk);
        #1 check("mid_rel_in_ready", 128'(vif.in_ready), 128'(1));
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (vif.out_valid) stale = 1'b1;
        end
        check("mid_no_stale", 128'(stale), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
